sd_fifo_tail_c: RTL
===================

SD_FIFO_TAIL_C -- requirements
Module: sd_fifo_tail_c

Interface
REQ-001 SHALL have parameter width, default 8, data word width in bits.
REQ-002 SHALL have parameter depth, default 16, memory words addressable (not required to be a power of 2).
REQ-003 SHALL have parameter commit, default 0, where 1 enables read/commit/abort.
REQ-004 SHALL have parameter rd_lat, default 1, memory read latency in cycles (legal 1..4).
REQ-005 SHALL have derived parameters asz=$clog2(depth) and usz=$clog2(depth+1).
REQ-006 SHALL have ports:
- clk  in  1  clock; all flops on posedge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  arbitration grant; reads issue only while high.
- bound_low  in  asz  first address of this FIFO's region.
- bound_high  in  asz  last address of this FIFO's region.
- wrptr  in  asz  head write pointer.
- cur_rdptr  out  asz  next address to read.
- com_rdptr  out  asz  committed read pointer, returned to the head.
- mem_re  out  1  memory read strobe, address = cur_rdptr.
- mem_rd_data  in  width  read data, valid rd_lat cycles after mem_re.
- p_usage  out  usz+1  words held between com_rdptr and wrptr.
- p_srdy  out  1  output word valid.
- p_drdy  in  1  consumer ready.
- p_commit  in  1  commit qualifier on transfer (commit=1 only).
- p_abort  in  1  rewind to last commit (commit=1 only).
- p_data  out  width  output word.

Function
REQ-007 SHALL treat a transfer as p_srdy & p_drdy in the same cycle.
REQ-008 SHALL compute cur_rdptr_p1 = bound_low when cur_rdptr == bound_high, else cur_rdptr+1; com_rdptr advances with the same wrap rule.
REQ-009 SHALL define empty as wrptr == cur_rdptr.
REQ-010 SHALL track outstanding reads (oc, 0..rd_lat) and buffered words (bc, 0..rd_lat+1) in an internal output buffer of rd_lat+1 entries.
REQ-011 SHALL assert mem_re iff enable & !empty & !(commit & p_abort) & (oc+bc < rd_lat+1, or oc+bc == rd_lat+1 with a transfer this cycle).
REQ-012 SHALL advance cur_rdptr to cur_rdptr_p1 on mem_re, otherwise hold it.
REQ-013 SHALL carry a valid bit (and, when commit=1, the read address) through an rd_lat-stage pipeline, writing mem_rd_data into the buffer when the valid bit emerges.
REQ-014 SHALL drive p_srdy = (bc != 0), with p_data at the buffer head; order equals read order; never drop or duplicate a word except on abort.
REQ-015 SHALL support a simultaneous buffer write and transfer in one cycle, leaving bc unchanged.
REQ-016 SHALL achieve minimum latency of rd_lat+1 cycles from mem_re to p_srdy, and full throughput of 1 word/cycle while p_drdy=1 and the FIFO is not empty.
REQ-017 SHALL, when commit=0, drive com_rdptr = cur_rdptr combinationally and ignore p_commit and p_abort.
REQ-018 SHALL, when commit=1 and a transfer occurs with p_commit=1, set com_rdptr next cycle to the transferred word's address plus 1 (wrapped).
REQ-019 SHALL, when commit=1 and p_abort=1, in the same cycle: force mem_re=0, load cur_rdptr <= com_rdptr, clear all pipeline valid bits, and set oc=0 and bc=0; p_abort takes priority over p_commit.
REQ-020 SHALL compute p_usage = wrptr-com_rdptr when wrptr >= com_rdptr, else (bound_high-bound_low+1)-(com_rdptr-wrptr), in usz+1 bits.
REQ-021 SHALL hold all state unchanged while enable=0, apart from returns of in-flight reads and transfers.

Reset
REQ-022 SHALL, on reset assertion, asynchronously set cur_rdptr=bound_low, com_rdptr=bound_low (commit=1), oc=0, bc=0, pipeline valids=0, p_srdy=0, mem_re=0.
REQ-023 SHALL, on reset mid-operation, discard all in-flight and buffered words with no output transfer after reset, and resume normally on the first clock after deassertion.

Verification
REQ-024 SHALL cover reset: width=8, depth=16, rd_lat=2, bounds 0..15, reset pulse mid-stream -> cur_rdptr=0, p_srdy=0, p_usage=0 immediately.
REQ-025 SHALL cover streaming: wrptr 0->3, p_drdy=1 -> mem_re high for 3 cycles; p_srdy first high 3 cycles after the first mem_re; words 0,1,2 in order.
REQ-026 SHALL cover backpressure: wrptr=10, p_drdy=0 -> exactly 3 mem_re pulses, then stall; after p_drdy=1, all 10 words arrive in order with none lost.
REQ-027 SHALL cover wrap: bounds 4..9, wrptr=5, cur_rdptr=9 -> reads at 9 then 4; cur_rdptr ends at 5.
REQ-028 SHALL cover commit/abort: commit=1, 5 words, commit on the 2nd, abort after the 4th -> cur_rdptr=2, words 2,3,4 replayed after rd_lat+1 cycles.
REQ-029 SHALL cover usage wrap: bounds 0..15, wrptr=2, com_rdptr=12 -> p_usage=6.

Source files
------------

// File: rtl/sd_fifo_tail_c.sv
// sd_fifo_tail_c: read side of a FIFO living in a region of shared memory.
// Issues reads at cur_rdptr and rebuffers the returned words in a small buffer
// sized to cover rd_lat, so a consumer sees one word per cycle once data is flowing.
// With commit=1 the consumer can mark words consumed (p_commit) or rewind to the
// last committed word (p_abort).
// Ports: clk/reset; enable = arbitration grant; bound_low/bound_high = region;
//   wrptr = head write pointer; cur_rdptr/com_rdptr = read/committed pointers;
//   mem_re/mem_rd_data = memory read port; p_usage = words held;
//   p_srdy/p_drdy/p_data/p_commit/p_abort = consumer side.
module sd_fifo_tail_c #(
  parameter int width  = 8,
  parameter int depth  = 16,
  parameter int commit = 0,
  parameter int rd_lat = 1,
  parameter int asz    = $clog2(depth),
  parameter int usz    = $clog2(depth + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [asz-1:0]   bound_low,
  input  logic [asz-1:0]   bound_high,
  input  logic [asz-1:0]   wrptr,
  output logic [asz-1:0]   cur_rdptr,
  output logic [asz-1:0]   com_rdptr,
  output logic             mem_re,
  input  logic [width-1:0] mem_rd_data,
  output logic [usz:0]     p_usage,
  output logic             p_srdy,
  input  logic             p_drdy,
  input  logic             p_commit,
  input  logic             p_abort,
  output logic [width-1:0] p_data
);

  localparam int nb  = rd_lat + 1;       // buffer entries
  localparam int bw  = $clog2(nb);
  localparam int cw  = $clog2(nb + 1);   // counters hold 0..nb
  localparam int cw1 = cw + 1;
  localparam int uw  = usz + 1;

  localparam logic [asz-1:0] adr_one = asz'(1);
  localparam logic [bw-1:0]  bp_one  = bw'(1);
  localparam logic [bw-1:0]  bp_last = bw'(nb - 1);
  localparam logic [cw-1:0]  cnt_one = cw'(1);
  localparam logic [cw:0]    cnt_nb  = cw1'(nb);
  localparam logic [usz:0]   use_one = uw'(1);

  logic [asz-1:0]    com_q;
  logic [asz-1:0]    cur_rdptr_p1;
  logic [rd_lat-1:0] vld_pipe;
  logic [asz-1:0]    adr_pipe [rd_lat];
  logic [width-1:0]  buf_dat  [nb];
  logic [asz-1:0]    buf_adr  [nb];
  logic [bw-1:0]     wp, rp;
  logic [cw-1:0]     oc, bc, oc_nx, bc_nx;
  logic [cw:0]       occ;
  logic              empty, xfer, abort, ret;
  logic [usz:0]      wr_x, com_x, lo_x, hi_x;

  function automatic logic [asz-1:0] inc_adr(input logic [asz-1:0] a,
                                             input logic [asz-1:0] lo,
                                             input logic [asz-1:0] hi);
    return (a == hi) ? lo : a + adr_one;
  endfunction

  function automatic logic [bw-1:0] inc_bp(input logic [bw-1:0] p);
    return (p == bp_last) ? '0 : p + bp_one;
  endfunction

  assign abort        = (commit == 1) && p_abort;
  assign cur_rdptr_p1 = inc_adr(cur_rdptr, bound_low, bound_high);
  assign empty        = (wrptr == cur_rdptr);
  assign xfer         = p_srdy & p_drdy;
  assign ret          = vld_pipe[rd_lat-1];
  assign occ          = {1'b0, oc} + {1'b0, bc};

  // A read may be issued into a full reservation only if a word leaves this cycle.
  assign mem_re = !reset && enable && !empty && !abort &&
                  ((occ < cnt_nb) || ((occ == cnt_nb) && xfer));

  assign p_srdy    = (bc != '0);
  assign p_data    = buf_dat[rp];
  assign com_rdptr = (commit == 1) ? com_q : cur_rdptr;

  // Usage is measured from the committed pointer, wrapping within the region.
  assign wr_x    = uw'(wrptr);
  assign com_x   = uw'(com_rdptr);
  assign lo_x    = uw'(bound_low);
  assign hi_x    = uw'(bound_high);
  assign p_usage = (wrptr >= com_rdptr) ? (wr_x - com_x)
                                        : ((hi_x - lo_x + use_one) - (com_x - wr_x));

  always_comb begin
    oc_nx = oc;
    bc_nx = bc;
    if (mem_re) oc_nx = oc_nx + cnt_one;
    if (ret) begin
      oc_nx = oc_nx - cnt_one;
      bc_nx = bc_nx + cnt_one;
    end
    if (xfer) bc_nx = bc_nx - cnt_one;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_rdptr <= bound_low;
      com_q     <= bound_low;
      vld_pipe  <= '0;
      oc        <= '0;
      bc        <= '0;
      wp        <= '0;
      rp        <= '0;
    end else if (abort) begin
      // Rewind: anything in flight or buffered will be re-read from com_q.
      cur_rdptr <= com_q;
      vld_pipe  <= '0;
      oc        <= '0;
      bc        <= '0;
      wp        <= '0;
      rp        <= '0;
    end else begin
      if (mem_re) cur_rdptr <= cur_rdptr_p1;
      for (int i = rd_lat - 1; i > 0; i--) vld_pipe[i] <= vld_pipe[i-1];
      vld_pipe[0] <= mem_re;
      oc <= oc_nx;
      bc <= bc_nx;
      if (ret)  wp <= inc_bp(wp);
      if (xfer) rp <= inc_bp(rp);
      if (xfer && p_commit) com_q <= inc_adr(buf_adr[rp], bound_low, bound_high);
    end
  end

  // Address pipeline and buffer storage need no reset; validity lives in vld_pipe/bc.
  always_ff @(posedge clk) begin
    adr_pipe[0] <= cur_rdptr;
    for (int i = 1; i < rd_lat; i++) adr_pipe[i] <= adr_pipe[i-1];
    if (ret) begin
      buf_dat[wp] <= mem_rd_data;
      buf_adr[wp] <= adr_pipe[rd_lat-1];
    end
  end

endmodule
